// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and entry type for the instruction fetch front end
//
// Holds the default address/instruction widths, the default reset PC, the
// instruction size in bytes and the packed {instr, pc} entry used by the FIFO.
package fetch_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 64;
  localparam int DEFAULT_INSTR_WIDTH = 32;
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] DEFAULT_RESET_PC = '0;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [DEFAULT_INSTR_WIDTH-1:0] instr;
    logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, used for fetched words and PC tags
//
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   i_push, i_data     write one entry
//   i_pop              remove the head entry (ignored when empty)
//   i_flush            drop every entry; dominates push and pop
//   o_data             head entry (stale when empty)
//   o_full, o_empty    status
//   o_count            number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output T                         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: the empty flag qualifies every read.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetN)
    !(i_push && o_full && !i_pop && !i_flush));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: PC, credit-limited requests, response FIFO, redirect flush
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (same-cycle forwarding of a
// response to the output when the FIFO is empty).
//
// Ports:
//   clk, resetN                     clock, asynchronous active-low reset
//   imemReqValid/Ready/Addr         in-order fetch requests, 4-byte aligned
//   imemRespValid/Data              in-order instruction returns
//   redirectValid/redirectPc        branch redirect: flush and refetch
//   outValid/outReady/outInstr/outPc  instruction + PC to decode
//   occupancy                       valid FIFO entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     resetN,
  output logic                     imemReqValid,
  input  logic                     imemReqReady,
  output logic [ADDR_WIDTH-1:0]    imemReqAddr,
  input  logic                     imemRespValid,
  input  logic [INSTR_WIDTH-1:0]   imemRespData,
  input  logic                     redirectValid,
  input  logic [ADDR_WIDTH-1:0]    redirectPc,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [INSTR_WIDTH-1:0]   outInstr,
  output logic [ADDR_WIDTH-1:0]    outPc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_discard;

  logic                  w_req_fire;
  logic                  w_resp_live;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [CW-1:0]         w_count;
  entry_t                w_push_entry;
  entry_t                w_head;
  logic [ADDR_WIDTH-1:0] w_tag_pc;
  logic                  w_tag_empty;
  logic                  w_tag_full;
  logic [CW-1:0]         w_tag_count;
  logic [CW:0]           w_credit_used;
  logic [CW-1:0]         w_out_after_resp;

  // Every buffered word and every in-flight request (stale ones included)
  // holds a credit, which is what keeps the FIFO from ever overflowing.
  assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imemReqValid  = resetN && !redirectValid && (w_credit_used < (CW+1)'(DEPTH));
  assign imemReqAddr   = r_fetch_pc;
  assign w_req_fire    = imemReqValid && imemReqReady;

  assign w_resp_live   = imemRespValid && (r_discard == '0) && !redirectValid;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_resp_live && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word taken by the consumer this cycle never enters the FIFO.
  assign w_push       = w_resp_live && !(w_bypass && outReady);
  assign w_push_entry = '{instr: imemRespData, pc: w_tag_pc};
  assign w_pop        = !w_fifo_empty && outReady;

  assign outValid  = !w_fifo_empty || w_bypass;
  assign occupancy = w_count;

  always_comb begin
    outInstr = '0;
    outPc    = '0;
    if (!w_fifo_empty) begin
      outInstr = w_head.instr;
      outPc    = w_head.pc;
    end else if (w_bypass) begin
      outInstr = imemRespData;
      outPc    = w_tag_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_data_fifo (
    .clk     (clk),
    .resetN  (resetN),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirectValid),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  // PCs of live in-flight requests, oldest first; discarded responses never pop it.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [ADDR_WIDTH-1:0])
  ) u_tag_fifo (
    .clk     (clk),
    .resetN  (resetN),
    .i_push  (w_req_fire),
    .i_data  (r_fetch_pc),
    .i_pop   (w_resp_live),
    .i_flush (redirectValid),
    .o_data  (w_tag_pc),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  // No request issues in a redirect cycle, so only a response can change it then.
  assign w_out_after_resp = r_outstanding - CW'(imemRespValid);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirectValid) begin
      r_fetch_pc    <= redirectPc & ~ADDR_WIDTH'(INSTR_BYTES - 1);
      r_outstanding <= w_out_after_resp;
      // Everything still in flight is now stale and must be thrown away.
      r_discard     <= w_out_after_resp;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
      r_outstanding <= w_out_after_resp + CW'(w_req_fire);
      if (imemRespValid && (r_discard != '0)) r_discard <= r_discard - 1'b1;
    end
  end

  a_credit_cap: assert property (@(posedge clk) disable iff (!resetN)
    w_credit_used <= (CW+1)'(DEPTH));
  a_tag_present: assert property (@(posedge clk) disable iff (!resetN)
    !(w_resp_live && w_tag_empty));
  a_tag_room: assert property (@(posedge clk) disable iff (!resetN)
    !(w_req_fire && w_tag_full));
  a_tag_bound: assert property (@(posedge clk) disable iff (!resetN)
    w_tag_count <= r_outstanding);
  a_full_blocks: assert property (@(posedge clk) disable iff (!resetN)
    !(w_fifo_full && imemReqValid));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;

  localparam int AW    = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int VW    = 1 + AW + 1 + IW + AW + 3;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetN;
  logic           imemReqValid, imemReqReady, imemRespValid;
  logic [AW-1:0]  imemReqAddr, redirectPc, outPc;
  logic [IW-1:0]  imemRespData, outInstr;
  logic           redirectValid, outValid, outReady;
  logic [2:0]     occupancy;

  logic           wr_req_valid, wr_out_valid;
  logic [AW-1:0]  wr_req_addr, wr_out_pc;
  logic [IW-1:0]  wr_out_instr;
  logic [2:0]     wr_occ;

  fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .resetN(resetN),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outPc(outPc),
    .occupancy(occupancy)
  );

  fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH),
                .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_wrap (
    .clk(clk), .resetN(resetN),
    .imemReqValid(wr_req_valid), .imemReqReady(1'b1), .imemReqAddr(wr_req_addr),
    .imemRespValid(1'b0), .imemRespData('0),
    .redirectValid(1'b0), .redirectPc('0),
    .outValid(wr_out_valid), .outReady(1'b0), .outInstr(wr_out_instr), .outPc(wr_out_pc),
    .occupancy(wr_occ)
  );

  typedef struct { logic [AW-1:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [IW-1:0] instr; logic [AW-1:0] pc; } ent_t;

  req_t          mq[$];   // memory in flight, oldest first
  ent_t          mf[$];   // words the block should be holding
  logic [AW-1:0] m_pc;
  int            cyc;

  int            lat;
  bit            k_req_ready, k_out_ready, k_redir;
  logic [AW-1:0] k_redir_pc;

  logic [VW-1:0] v_obs, v_exp;
  bit            o_req_fire, o_pop;
  int            c_now;

  int errors = 0;
  int checks = 0;

  task automatic do_reset();
    resetN = 1'b0;
    imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = '0;
    redirectValid = 1'b0; redirectPc = '0; outReady = 1'b0;
    k_req_ready = 1'b0; k_out_ready = 1'b0; k_redir = 1'b0; k_redir_pc = '0; lat = 1;
    mq.delete(); mf.delete(); m_pc = '0; cyc = 0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  // Drives one cycle from the knobs, records DUT outputs and model predictions,
  // then advances the model across the coming clock edge.
  task automatic cycle();
    bit resp_v, live, byp, e_req_valid, e_out_valid;
    ent_t hd;
    req_t r;
    @(negedge clk);
    resp_v = (mq.size() > 0) && (mq[0].due <= cyc);
    imemRespValid = resp_v;
    imemRespData  = resp_v ? mq[0].addr[IW-1:0] : '0;
    imemReqReady  = k_req_ready;
    outReady      = k_out_ready;
    redirectValid = k_redir;
    redirectPc    = k_redir_pc;
    #1;
    e_req_valid = (mf.size() + mq.size() < DEPTH) && !k_redir;
    live        = resp_v && !mq[0].stale && !k_redir;
    byp         = BYP && live && (mf.size() == 0);
    e_out_valid = (mf.size() > 0) || byp;
    hd = '{instr: '0, pc: '0};
    if (mf.size() > 0) hd = mf[0];
    else if (byp) hd = '{instr: mq[0].addr[IW-1:0], pc: mq[0].addr};
    v_exp = {e_req_valid, m_pc, e_out_valid, hd.instr, hd.pc, 3'(mf.size())};
    v_obs = {imemReqValid, imemReqAddr, outValid, outInstr, outPc, occupancy};
    o_req_fire = e_req_valid && k_req_ready;
    o_pop      = e_out_valid && k_out_ready;
    c_now      = cyc;
    if (o_pop && mf.size() > 0) void'(mf.pop_front());
    if (resp_v) begin
      r = mq.pop_front();
      if (live && !(byp && k_out_ready)) mf.push_back('{instr: r.addr[IW-1:0], pc: r.addr});
    end
    if (o_req_fire) begin
      mq.push_back('{addr: m_pc, due: cyc + lat, stale: 1'b0});
      m_pc = m_pc + 64'd4;
    end
    if (k_redir) begin
      mf.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_pc = k_redir_pc & ~64'd3;
    end
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    k_req_ready = 1'b1; k_out_ready = 1'b0; lat = 1;
    repeat (4) cycle();
    #2 resetN = 1'b0;
    #1;
    checks++; if (imemReqValid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imemReqValid); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", outValid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (outInstr !== '0 || outPc !== '0) begin errors++; $display("FAIL reset_out_data got=%h/%h exp=0/0", outInstr, outPc); end
    checks++; if (imemReqAddr !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", imemReqAddr); end
  endtask

  task automatic test_stream();
    int n_req, first_req, first_out;
    n_req = 0; first_req = -1; first_out = -1;
    do_reset();
    k_req_ready = 1'b1; k_out_ready = 1'b1; lat = 1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      checks++; if (v_obs !== v_exp) begin errors++; $display("FAIL stream c=%0d got=%h exp=%h", c_now, v_obs, v_exp); end
      if (imemReqValid && n_req < 3) begin
        checks++; if (imemReqAddr !== 64'(n_req * 4)) begin errors++; $display("FAIL stream_addr n=%0d got=%h exp=%h", n_req, imemReqAddr, 64'(n_req * 4)); end
        n_req++;
      end
      if (o_req_fire && first_req < 0) first_req = c_now;
      if (outValid && first_out < 0) first_out = c_now;
    end
    checks++; if (first_out - first_req !== (BYP ? 1 : 2)) begin errors++; $display("FAIL stream_latency got=%0d exp=%0d", first_out - first_req, BYP ? 1 : 2); end
  endtask

  task automatic test_backpressure();
    int n_acc, n_drained;
    logic [AW-1:0] first_resume;
    logic [AW-1:0] drained [4];
    n_acc = 0; n_drained = 0; first_resume = '1;
    do_reset();
    k_req_ready = 1'b1; k_out_ready = 1'b0; lat = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++; if (v_obs !== v_exp) begin errors++; $display("FAIL bp_fill c=%0d got=%h exp=%h", c_now, v_obs, v_exp); end
      if (imemReqValid) n_acc++;
    end
    checks++; if (n_acc !== DEPTH) begin errors++; $display("FAIL bp_accepted got=%0d exp=%0d", n_acc, DEPTH); end
    checks++; if (occupancy !== 3'd4 || imemReqValid !== 1'b0) begin errors++; $display("FAIL bp_full occ=%0d req=%b exp=4/0", occupancy, imemReqValid); end
    k_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++; if (v_obs !== v_exp) begin errors++; $display("FAIL bp_drain c=%0d got=%h exp=%h", c_now, v_obs, v_exp); end
      if (outValid && n_drained < 4) begin drained[n_drained] = outPc; n_drained++; end
      if (imemReqValid && first_resume === '1) first_resume = imemReqAddr;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (drained[i] !== 64'(i * 4)) begin errors++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, drained[i], 64'(i * 4)); end
    end
    checks++; if (first_resume !== 64'h10) begin errors++; $display("FAIL bp_resume got=%h exp=10", first_resume); end
  endtask

  task automatic test_redirect();
    logic [AW-1:0] first_req, first_out;
    first_req = '1; first_out = '1;
    do_reset();
    k_req_ready = 1'b1; k_out_ready = 1'b1; lat = 3;
    for (int i = 0; i < 16; i++) begin
      k_redir = (i == 3); k_redir_pc = 64'h1003;
      cycle();
      checks++; if (v_obs !== v_exp) begin errors++; $display("FAIL redirect c=%0d got=%h exp=%h", c_now, v_obs, v_exp); end
      if (i > 3 && imemReqValid && first_req === '1) first_req = imemReqAddr;
      if (outValid && first_out === '1) first_out = outPc;
    end
    checks++; if (first_req !== 64'h1000) begin errors++; $display("FAIL redirect_addr got=%h exp=1000", first_req); end
    checks++; if (first_out !== 64'h1000) begin errors++; $display("FAIL redirect_first_out got=%h exp=1000", first_out); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    k_req_ready = 1'b1; k_out_ready = 1'b0; lat = 1;
    repeat (2) cycle();
    k_redir = 1'b1; k_redir_pc = 64'h200; k_out_ready = 1'b1;
    cycle();
    checks++; if (imemRespValid !== 1'b1 || outValid !== 1'b1 || outPc !== 64'h0) begin errors++; $display("FAIL rp_pop resp=%b valid=%b pc=%h exp=1/1/0", imemRespValid, outValid, outPc); end
    k_redir = 1'b0; k_out_ready = 1'b0;
    cycle();
    checks++; if (occupancy !== 3'd0 || outValid !== 1'b0) begin errors++; $display("FAIL rp_after occ=%0d valid=%b exp=0/0", occupancy, outValid); end
    checks++; if (v_obs !== v_exp) begin errors++; $display("FAIL rp_model got=%h exp=%h", v_obs, v_exp); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_addr[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_addr[2] = 64'h0;                   exp_addr[3] = 64'h4;
    do_reset();
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle();
      if (i < 4) begin
        checks++; if (wr_req_valid !== 1'b1 || wr_req_addr !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr i=%0d got=%b/%h exp=1/%h", i, wr_req_valid, wr_req_addr, exp_addr[i]); end
      end else begin
        checks++; if (wr_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_cap got=%b exp=0", wr_req_valid); end
      end
    end
    checks++; if (wr_out_valid !== 1'b0 || wr_occ !== 3'd0 || wr_out_pc !== '0 || wr_out_instr !== '0) begin
      errors++; $display("FAIL wrap_idle got=%b/%0d/%h/%h exp=0/0/0/0", wr_out_valid, wr_occ, wr_out_pc, wr_out_instr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      k_req_ready = ($urandom_range(0, 3) != 0);
      k_out_ready = ($urandom_range(0, 2) != 0);
      lat         = $urandom_range(1, 4);
      k_redir     = ($urandom_range(0, 19) == 0) || (i >= 300 && i < 303);
      k_redir_pc  = {$urandom, $urandom};
      cycle();
      checks++; if (v_obs !== v_exp) begin errors++; $display("FAIL random c=%0d got=%h exp=%h", c_now, v_obs, v_exp); end
    end
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    k_req_ready = 1'b1; k_out_ready = 1'b1; lat = 1;
    cycle();
    for (int i = 1; i < 7; i++) begin
      cycle();
      checks++; if (outValid !== 1'b1 || occupancy !== 3'd0 || outInstr !== 32'(4 * (i - 1))) begin
        errors++; $display("FAIL bypass i=%0d got=%b/%0d/%h exp=1/0/%h", i, outValid, occupancy, outInstr, 32'(4 * (i - 1)));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_random();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of decode/control and the register file.
- Owns the fetch PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a small FIFO.
- Presents instruction/PC pairs downstream with valid/ready.
- Accepts a branch redirect that flushes buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 64, width of PC and memory address.
- INSTR_WIDTH, 32, width of one instruction word.
- DEPTH, 4, FIFO entries; also the cap on outstanding memory requests. Power of two, ≥2.
- RESET_PC, 0, fetch PC loaded at reset.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- imemReqValid  out  1  fetch request valid.
- imemReqReady  in  1  memory accepts request.
- imemReqAddr  out  ADDR_WIDTH  fetch address, always 4-byte aligned.
- imemRespValid  in  1  instruction returned; responses arrive in request order, ≥1 cycle after acceptance.
- imemRespData  in  INSTR_WIDTH  returned instruction.
- redirectValid  in  1  branch taken; flush and refetch.
- redirectPc  in  ADDR_WIDTH  redirect target.
- outValid  out  1  instruction available.
- outReady  in  1  consumer takes instruction.
- outInstr  out  INSTR_WIDTH  head instruction.
- outPc  out  ADDR_WIDTH  PC of outInstr.
- occupancy  out  $clog2(DEPTH)+1  valid FIFO entries.

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low (resetN).
- Reset values:
  - fetchPc = RESET_PC; FIFO empty.
  - outstanding = 0; discard = 0.
  - imemReqValid = 0, outValid = 0, occupancy = 0.
  - outInstr = 0, outPc = 0.
- Reset asserted mid-operation clears everything immediately. In-flight responses arriving after reset release are the memory's responsibility; the memory must be reset together with this block.
- Request issue:
  - imemReqValid = (occupancy + outstanding < DEPTH) && !redirectValid.
  - imemReqAddr = fetchPc.
  - On request handshake: outstanding += 1; fetchPc += 4, modulo 2^ADDR_WIDTH (wraps silently).
- Response handling:
  - On imemRespValid with discard == 0: push {imemRespData, pcTag} into the FIFO; outstanding -= 1.
  - pcTag comes from an internal in-order PC tag queue of depth DEPTH.
  - The credit rule guarantees the FIFO never overflows. A push into a full FIFO is a design error; flag it with an assertion.
- Output:
  - outValid = FIFO not empty; outInstr/outPc = head entry.
  - Pop on outValid && outReady.
  - Default latency from response to outValid is 1 cycle (registered FIFO).
- Redirect, in the cycle redirectValid = 1:
  - FIFO and PC tag queue flushed.
  - fetchPc <= {redirectPc[ADDR_WIDTH-1:2], 2'b00}; low bits are ignored.
  - discard <= outstanding minus any response consumed this cycle.
  - outstanding <= same value.
  - No request is issued this cycle.
  - A response arriving in the same cycle is dropped.
  - A pop in the same cycle completes (the consumer has the word), then the flush applies.
- Discard: while discard > 0, each imemRespValid decrements both discard and outstanding, with no push.
- Back-to-back redirects: each redirect reloads fetchPc. discard accumulates correctly because outstanding already includes the stale requests.
- Counters never exceed DEPTH; no under- or overflow is reachable with legal memory behaviour.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- When defined: if the FIFO is empty, a non-discarded response is driven combinationally onto outInstr/outPc with outValid = 1 in the same cycle.
  - If outReady is also 1, the word is consumed without entering the FIFO (zero-cycle latency).
  - If outReady is 0, the word is pushed as normal.
  - A same-cycle redirect suppresses the bypass.
- When undefined: pure registered path, latency 1.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_WIDTH and INSTR_WIDTH defaults;
  - RESET_PC;
  - INSTR_BYTES = 4;
  - a packed struct fetch_entry_t {instr, pc}.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count. It is reused for the PC tag queue.
- Credit, discard and PC logic stay in fetch_queue.

Test Plan:
- Reset release, imemReqReady = 1, 1-cycle memory returning addr as data, outReady = 1:
  - addresses issued are 0x0, 0x4, 0x8 …;
  - outPc/outInstr pairs match;
  - the first outValid appears 2 cycles after the first request.
- outReady = 0 permanently:
  - exactly DEPTH = 4 requests are accepted;
  - imemReqValid then stays 0 and occupancy = 4;
  - on raising outReady, entries drain in order 0x0–0xC and fetch resumes at 0x10.
- 3-cycle memory latency with 3 requests outstanding; redirectValid with redirectPc = 0x1003:
  - the 3 stale responses are dropped;
  - the next request address is 0x1000;
  - the first outPc = 0x1000.
- Redirect in the same cycle as a response and a pop:
  - the popped word is delivered;
  - the response is discarded;
  - occupancy = 0 the next cycle.
- RESET_PC = 0xFFFF_FFFF_FFFF_FFF8:
  - requests issue at …FFF8, …FFFC, then 0x0 (wrap).
- With FETCH_QUEUE_BYPASS_EN, empty FIFO, outReady = 1:
  - response data appears on outInstr in the same cycle;
  - occupancy stays 0.
